// File: rtl/fifo_wr_arb_if.sv
// rtl/fifo_wr_arb_if.sv - requester streams and FIFO write port of fifo_wr_arb
interface fifo_wr_arb_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*DSIZE-1:0]   req_data;
  logic [NREQ-1:0]         req_last;
  logic [NREQ-1:0]         req_ready;
  logic [DSIZE-1:0]        wdata;
  logic                    winc;
  logic                    wfull;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                    busy;

  modport master (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, wdata, winc, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, wdata, winc, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter sharing the async FIFO write port
module fifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic          wclk,
  input  logic          wrst,
  fifo_wr_arb_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] grant_q, grant_nxt, rr_ptr, rr_nxt, pick, grant_inc;
  logic [CW-1:0] count, count_nxt;
  logic          found, transfer, release_now;
  int            idx;

  // first valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && bus.req_valid[IW'(idx)]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign grant_inc = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
  assign transfer  = (state == GRANT) && bus.req_valid[grant_q] && !bus.wfull && !wrst;
  assign release_now = (transfer && (bus.req_last[grant_q] || count == CW'(BURST - 1)))
                     || !bus.req_valid[grant_q];

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      rr_ptr  <= rr_nxt;
      count   <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    rr_nxt    = rr_ptr;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          count_nxt = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (transfer) count_nxt = count + 1'b1;
        // wfull alone never releases; last counts only once it is accepted
        if (release_now) begin
          state_nxt = IDLE;
          rr_nxt    = grant_inc;
          count_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (transfer) bus.req_ready[grant_q] = 1'b1;
    bus.winc     = transfer;
    bus.wdata    = (state == GRANT) ? bus.req_data[grant_q*DSIZE +: DSIZE] : '0;
    bus.grant_id = grant_q;
    bus.busy     = (state == GRANT);
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - randomized and directed bench for fifo_wr_arb against a rule-level model
module tb_fifo_wr_arb;
  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  fifo_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  // producer word queues as ring buffers: {last, data}
  logic [8:0] mem [NREQ][256];
  int hd [NREQ];
  int tl [NREQ];

  // model of the arbiter's rules
  bit m_gnt;
  int m_g, m_ptr, m_sent;

  // observations from the latest step
  logic [7:0] wlog [$];
  int         glog [$];
  bit         prev_busy;
  bit         o_busy, o_winc;
  int         o_gid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic last);
    mem[i][tl[i] % 256] = {last, d};
    tl[i]++;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
  endtask

  task automatic step(input bit full, input bit rst);
    logic [NREQ-1:0]       v, l, e_ready;
    logic [NREQ*DSIZE-1:0] d;
    logic [7:0]            e_wdata;
    bit                    xfer;
    @(negedge wclk);
    for (int i = 0; i < NREQ; i++) begin
      v[i] = (tl[i] > hd[i]);
      d[i*DSIZE +: DSIZE] = v[i] ? mem[i][hd[i] % 256][7:0] : 8'h00;
      l[i] = v[i] ? mem[i][hd[i] % 256][8] : 1'b0;
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    bus.wfull     = full;
    wrst          = rst;
    #2;
    xfer    = m_gnt && v[m_g] && !full && !rst;
    e_ready = '0;
    if (xfer) e_ready[m_g] = 1'b1;
    e_wdata = m_gnt ? d[m_g*DSIZE +: DSIZE] : 8'h00;
    check("winc",     32'(bus.winc),      32'(xfer));
    check("ready",    32'(bus.req_ready), 32'(e_ready));
    check("wdata",    32'(bus.wdata),     32'(e_wdata));
    check("busy",     32'(bus.busy),      32'(m_gnt));
    check("grant_id", 32'(bus.grant_id),  32'(m_g));
    o_busy = bus.busy;
    o_winc = bus.winc;
    o_gid  = int'(bus.grant_id);
    if (bus.winc) wlog.push_back(bus.wdata);
    if (bus.busy && !prev_busy) glog.push_back(int'(bus.grant_id));
    prev_busy = bus.busy;
    if (rst) begin
      m_gnt = 0; m_g = 0; m_ptr = 0; m_sent = 0;
    end else if (m_gnt) begin
      if (xfer) begin
        m_sent++;
        hd[m_g]++;
      end
      if ((xfer && (l[m_g] || m_sent == BURST)) || !v[m_g]) begin
        m_gnt  = 0;
        m_ptr  = (m_g + 1) % NREQ;
        m_sent = 0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!m_gnt && v[(m_ptr + k) % NREQ]) begin
          m_gnt  = 1;
          m_g    = (m_ptr + k) % NREQ;
          m_sent = 0;
        end
      end
    end
    @(posedge wclk);
  endtask

  initial begin
    int wstart, n, busy_seen;
    clear_queues();
    m_gnt = 0; m_g = 0; m_ptr = 0; m_sent = 0; prev_busy = 0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.wfull = 1'b0;
    @(posedge wclk);
    @(posedge wclk);

    // reset with random requests pending
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NREQ; i++) if ($urandom_range(1) == 1) push(i, 8'($urandom), 1'b0);
      step(1'($urandom_range(1)), 1'b1);
      check("rst_winc", 32'(o_winc), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_gid",  32'(o_gid),  32'd0);
    end
    clear_queues();
    push(2, 8'h21, 1'b1);
    push(3, 8'h31, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rst_first_grant", 32'(o_gid), 32'd2);

    // single requester, three words
    step(1'b0, 1'b1);
    clear_queues();
    wstart = wlog.size();
    push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0);
    check("single_cnt", 32'(wlog.size() - wstart), 32'd3);
    if (wlog.size() - wstart == 3) begin
      check("single_w0", 32'(wlog[wstart]),     32'hA1);
      check("single_w1", 32'(wlog[wstart + 1]), 32'hA2);
      check("single_w2", 32'(wlog[wstart + 2]), 32'hA3);
    end
    check("single_gid", 32'(o_gid), 32'd1);

    // burst cap and rotation
    step(1'b0, 1'b1);
    clear_queues();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 30; j++) push(i, 8'(i * 16 + j), 1'b0);
    wstart = wlog.size();
    n = glog.size();
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0);
    check("rot_writes20", 32'(wlog.size() - wstart), 32'd16);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rot_grants", 32'(glog.size() - n), 32'd5);
    if (glog.size() - n == 5)
      for (int k = 0; k < 5; k++) check("rot_order", 32'(glog[n + k]), 32'(k % NREQ));

    // backpressure mid-burst
    step(1'b0, 1'b1);
    clear_queues();
    for (int j = 0; j < 6; j++) push(0, 8'(8'hB0 + j), 1'b0);
    wstart = wlog.size();
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
    busy_seen = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0);
      busy_seen += int'(o_busy);
    end
    check("bp_held", 32'(busy_seen), 32'd5);
    check("bp_frozen", 32'(wlog.size() - wstart), 32'd2);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
    check("bp_total", 32'(wlog.size() - wstart), 32'd4);
    check("bp_released", 32'(o_busy), 32'd0);

    // last presented under full
    step(1'b0, 1'b1);
    clear_queues();
    push(3, 8'hC3, 1'b1);
    wstart = wlog.size();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("lf_held", 32'(o_busy), 32'd1);
    step(1'b0, 1'b0);
    check("lf_write", 32'(o_winc), 32'd1);
    step(1'b0, 1'b0);
    check("lf_release", 32'(o_busy), 32'd0);
    check("lf_cnt", 32'(wlog.size() - wstart), 32'd1);

    // reset mid-burst
    step(1'b0, 1'b1);
    clear_queues();
    for (int j = 0; j < 4; j++) push(2, 8'(8'hD0 + j), 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("rmb_no_winc", 32'(o_winc), 32'd0);
    step(1'b0, 1'b0);
    check("rmb_idle", 32'(o_busy), 32'd0);
    step(1'b0, 1'b0);
    check("rmb_regrant", 32'(o_gid), 32'd2);
    check("rmb_left", 32'(tl[2] - hd[2]), 32'd1);

    // randomized traffic
    step(1'b0, 1'b1);
    clear_queues();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (tl[i] == hd[i] && $urandom_range(2) == 0) begin
          n = $urandom_range(1, 7);
          for (int j = 0; j < n; j++)
            push(i, 8'($urandom), (j == n - 1) ? 1'($urandom_range(1)) : 1'b0);
        end
      end
      step($urandom_range(99) < 25, $urandom_range(99) < 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
